// File: rtl/hazard_scoreboard.sv
// ID-stage producer scoreboard: per-register cycles-until-forwardable counters,
// load-use / multi-cycle stall generation and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int LAT_W = 3,
    parameter int CNT_W = 16,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [IDX_W-1:0] id_Ra,
    input  logic [IDX_W-1:0] id_Rb,
    input  logic             id_RegWrite,
    input  logic [IDX_W-1:0] id_Rw,
    input  logic [LAT_W-1:0] id_lat,
    input  logic             flush,
    output logic             stall,
    output logic             Ra_busy,
    output logic             Rb_busy,
    output logic [NREG-1:0]  pending,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [LAT_W-1:0] r_cnt [NREG];
    logic [CNT_W-1:0] r_stall_cycles;

    logic [LAT_W-1:0] w_lat_e;
    logic [LAT_W-1:0] w_load_val;
    logic             w_rec;

    assign w_lat_e    = (id_lat == '0) ? {{(LAT_W-1){1'b0}}, 1'b1} : id_lat;
    assign w_load_val = w_lat_e - {{(LAT_W-1){1'b0}}, 1'b1};

    // Busy checks read the pre-update count, so self-dependence needs no special case.
    assign Ra_busy = (id_Ra != '0) && (r_cnt[id_Ra] != '0);
    assign Rb_busy = (id_Rb != '0) && (r_cnt[id_Rb] != '0);
    assign stall   = id_valid && !flush && (Ra_busy || Rb_busy);
    assign w_rec   = id_valid && !flush && !stall && id_RegWrite && (id_Rw != '0);

    always_comb begin
        pending = '0;
        for (int r = 0; r < NREG; r++) begin
            pending[r] = (r_cnt[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            r_cnt[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (w_rec && (id_Rw == r[IDX_W-1:0])) begin
                    r_cnt[r] <= w_load_val;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - {{(LAT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if (stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected outputs are queued as each ID
// instruction is driven and popped/compared once the combinational outputs settle.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_Ra = '0;
    logic [4:0]  id_Rb = '0;
    logic        id_RegWrite = 1'b0;
    logic [4:0]  id_Rw = '0;
    logic [2:0]  id_lat = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        Ra_busy;
    logic        Rb_busy;
    logic [31:0] pending;
    logic [15:0] stall_cycles;

    hazard_scoreboard #(.NREG(32), .LAT_W(3), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_Ra        (id_Ra),
        .id_Rb        (id_Rb),
        .id_RegWrite  (id_RegWrite),
        .id_Rw        (id_Rw),
        .id_lat       (id_lat),
        .flush        (flush),
        .stall        (stall),
        .Ra_busy      (Ra_busy),
        .Rb_busy      (Rb_busy),
        .pending      (pending),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ra_busy;
        logic        rb_busy;
        logic [31:0] pend;
        logic [15:0] sc;
    } exp_t;

    exp_t        q[$];
    logic [2:0]  m_cnt [32];
    logic [15:0] m_sc;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string tag, input string what,
                       input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s %s: observed 0x%0h expected 0x%0h", tag, what, got, exp);
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) m_cnt[r] = '0;
        m_sc = '0;
    endtask

    // exp_stall is the hand-derived stall for this instruction; the model
    // supplies busy flags, pending bits and the stall counter.
    task automatic step(input string tag, input logic v, input logic [4:0] ra,
                        input logic [4:0] rb, input logic rw, input logic [4:0] rwi,
                        input logic [2:0] lat, input logic fl, input logic exp_stall);
        exp_t e;
        exp_t o;
        logic rec;
        logic [2:0] lat_e;
        @(negedge clk);
        id_valid = v; id_Ra = ra; id_Rb = rb; id_RegWrite = rw;
        id_Rw = rwi; id_lat = lat; flush = fl;
        e.stall   = exp_stall;
        e.ra_busy = (ra != 0) && (m_cnt[ra] != 0);
        e.rb_busy = (rb != 0) && (m_cnt[rb] != 0);
        for (int r = 0; r < 32; r++) e.pend[r] = (m_cnt[r] != 0);
        e.sc = m_sc;
        q.push_back(e);
        #1;
        o = q.pop_front();
        chk(tag, "stall", {31'b0, stall}, {31'b0, o.stall});
        chk(tag, "Ra_busy", {31'b0, Ra_busy}, {31'b0, o.ra_busy});
        chk(tag, "Rb_busy", {31'b0, Rb_busy}, {31'b0, o.rb_busy});
        chk(tag, "pending", pending, o.pend);
        chk(tag, "stall_cycles", {16'b0, stall_cycles}, {16'b0, o.sc});
        @(posedge clk);
        lat_e = (lat == 0) ? 3'd1 : lat;
        rec = v && !fl && !exp_stall && rw && (rwi != 0);
        for (int r = 1; r < 32; r++) begin
            if (rec && (rwi == r[4:0])) m_cnt[r] = lat_e - 3'd1;
            else if (m_cnt[r] != 0)     m_cnt[r] = m_cnt[r] - 3'd1;
        end
        if (exp_stall && (m_sc != 16'hFFFF)) m_sc = m_sc + 16'd1;
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        step("reset_idle", 0, 5'd0, 5'd0, 0, 5'd0, 3'd0, 0, 0);

        // load-use: exactly one stall cycle
        step("lu_load",   1, 5'd0, 5'd0, 1, 5'd4, 3'd2, 0, 0);
        step("lu_use0",   1, 5'd4, 5'd0, 0, 5'd0, 3'd0, 0, 1);
        step("lu_use1",   1, 5'd4, 5'd0, 0, 5'd0, 3'd0, 0, 0);
        step("lu_after",  0, 5'd0, 5'd0, 0, 5'd0, 3'd0, 0, 0);

        // ALU back-to-back: no stall, never pending
        step("alu_wr",    1, 5'd0, 5'd0, 1, 5'd7, 3'd1, 0, 0);
        step("alu_rd",    1, 5'd0, 5'd7, 0, 5'd0, 3'd0, 0, 0);

        // multi-cycle overwritten by a younger ALU writer
        step("ow_mul",    1, 5'd0, 5'd0, 1, 5'd9, 3'd5, 0, 0);
        step("ow_alu",    1, 5'd0, 5'd0, 1, 5'd9, 3'd1, 0, 0);
        step("ow_rd",     1, 5'd9, 5'd0, 0, 5'd0, 3'd0, 0, 0);

        // same reader without the overwrite: three stall cycles
        step("nw_mul",    1, 5'd0, 5'd0, 1, 5'd9, 3'd5, 0, 0);
        step("nw_other",  1, 5'd0, 5'd0, 1, 5'd10, 3'd1, 0, 0);
        step("nw_rd0",    1, 5'd9, 5'd0, 0, 5'd0, 3'd0, 0, 1);
        step("nw_rd1",    1, 5'd9, 5'd0, 0, 5'd0, 3'd0, 0, 1);
        step("nw_rd2",    1, 5'd9, 5'd0, 0, 5'd0, 3'd0, 0, 1);
        step("nw_rd3",    1, 5'd9, 5'd0, 0, 5'd0, 3'd0, 0, 0);

        // zero register never tracked
        step("z_wr",      1, 5'd0, 5'd0, 1, 5'd0, 3'd7, 0, 0);
        step("z_rd",      1, 5'd0, 5'd0, 0, 5'd0, 3'd0, 0, 0);

        // flushed writer is not recorded
        step("fl_wr",     1, 5'd0, 5'd0, 1, 5'd2, 3'd2, 1, 0);
        step("fl_rd",     1, 5'd2, 5'd0, 0, 5'd0, 3'd0, 0, 0);

        // flushed reader does not stall, producer keeps counting
        step("flr_wr",    1, 5'd0, 5'd0, 1, 5'd4, 3'd3, 0, 0);
        step("flr_fl",    1, 5'd4, 5'd0, 0, 5'd0, 3'd0, 1, 0);
        step("flr_rd0",   1, 5'd4, 5'd0, 0, 5'd0, 3'd0, 0, 1);
        step("flr_rd1",   1, 5'd4, 5'd0, 0, 5'd0, 3'd0, 0, 0);

        // invalid instruction with a busy source does not stall
        step("inv_wr",    1, 5'd0, 5'd0, 1, 5'd12, 3'd2, 0, 0);
        step("inv_rd",    0, 5'd12, 5'd12, 0, 5'd0, 3'd0, 0, 0);

        // latency 0 behaves as ALU
        step("l0_wr",     1, 5'd0, 5'd0, 1, 5'd11, 3'd0, 0, 0);
        step("l0_rd",     1, 5'd0, 5'd11, 0, 5'd0, 3'd0, 0, 0);

        // self-dependence: stalled instruction is not recorded until sources clear
        step("sd_wr",     1, 5'd0, 5'd0, 1, 5'd3, 3'd3, 0, 0);
        step("sd_s0",     1, 5'd3, 5'd1, 1, 5'd3, 3'd6, 0, 1);
        step("sd_s1",     1, 5'd3, 5'd1, 1, 5'd3, 3'd6, 0, 1);
        step("sd_go",     1, 5'd3, 5'd1, 1, 5'd3, 3'd6, 0, 0);
        step("sd_rd",     1, 5'd0, 5'd3, 0, 5'd0, 3'd0, 0, 1);

        // asynchronous reset mid-run with cnt[5]=3
        step("rst_wr",    1, 5'd0, 5'd0, 1, 5'd5, 3'd4, 0, 0);
        @(negedge clk);
        id_valid = 1'b1; id_Ra = 5'd5; id_Rb = 5'd0; id_RegWrite = 1'b0; flush = 1'b0;
        #1;
        chk("rst_pre", "stall", {31'b0, stall}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_async", "pending", pending, 32'd0);
        chk("rst_async", "stall", {31'b0, stall}, 32'd0);
        chk("rst_async", "stall_cycles", {16'b0, stall_cycles}, 32'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step("rst_rd",    1, 5'd5, 5'd0, 0, 5'd0, 3'd0, 0, 0);

        // saturation: one recording cycle then six stalled cycles, repeated
        for (int k = 0; k < 10925; k++) begin
            step("sat_wr", 1, 5'd0, 5'd0, 1, 5'd1, 3'd7, 0, 0);
            for (int j = 0; j < 6; j++)
                step("sat_rd", 1, 5'd1, 5'd0, 0, 5'd0, 3'd0, 0, 1);
        end
        step("sat_end",   0, 5'd0, 5'd0, 0, 5'd0, 3'd0, 0, 0);
        chk("sat_final", "stall_cycles", {16'b0, stall_cycles}, 32'h0000FFFF);
        step("sat_wr2",   1, 5'd0, 5'd0, 1, 5'd1, 3'd2, 0, 0);
        step("sat_hold",  1, 5'd1, 5'd0, 0, 5'd0, 3'd0, 0, 1);
        step("sat_idle",  0, 5'd0, 5'd0, 0, 5'd0, 3'd0, 0, 0);
        chk("sat_held", "stall_cycles", {16'b0, stall_cycles}, 32'h0000FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
